// File: rtl/prince_host_if.sv
// Host valid/ready wrapper for round-based PRINCE: accept -> start pulse -> wait act low -> hold result; 13 cycles accept to out_valid, 14-cycle throughput.
// One job in flight, in_ready low until the result is taken; PRINCE_IF_TIMEOUT_EN adds a RUN watchdog that sets sticky err.
module prince_host_if #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_pt,
  input  logic [127:0] in_key,
  input  logic         in_dec,
  output logic         core_st,
  input  logic         core_act,
  output logic [63:0]  core_pt,
  output logic [127:0] core_key,
  output logic         core_dec,
  input  logic [63:0]  core_ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_ct,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;
  state_t state;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // The controller has no reset, so a stale act from an aborted run must block new jobs.
  assign in_ready = rstn && (state == IDLE) && !core_act;

`ifdef PRINCE_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] run_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      core_st   <= 1'b0;
      core_pt   <= '0;
      core_key  <= '0;
      core_dec  <= 1'b0;
      out_valid <= 1'b0;
      out_ct    <= '0;
`ifdef PRINCE_IF_TIMEOUT_EN
      run_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            core_pt  <= in_pt;
            core_key <= in_key;
            core_dec <= in_dec;
            core_st  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          core_st <= 1'b0;
          state   <= RUN;
`ifdef PRINCE_IF_TIMEOUT_EN
          run_cnt <= '0;
`endif
        end
        RUN: begin
          if (!core_act) begin
            out_ct    <= core_ct;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
`ifdef PRINCE_IF_TIMEOUT_EN
          // run_cnt counts completed RUN cycles; this one is number run_cnt+1.
          else if (run_cnt >= CW'(TIMEOUT_CYC - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_host_if.sv
// Bench for prince_host_if: a behavioural controller/datapath stub plus directed and random jobs scored against expected results and latency.
module tb_prince_host_if;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_pt;
  logic [127:0] in_key;
  logic         in_dec;
  logic         core_st;
  logic         core_act;
  logic [63:0]  core_pt;
  logic [127:0] core_key;
  logic         core_dec;
  logic [63:0]  core_ct;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_ct;
  logic         err;

  int errors = 0;
  int checks = 0;

  prince_host_if #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .in_key(in_key), .in_dec(in_dec),
    .core_st(core_st), .core_act(core_act),
    .core_pt(core_pt), .core_key(core_key), .core_dec(core_dec),
    .core_ct(core_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known PRINCE vectors; any other operands get an arbitrary but deterministic mix.
  function automatic logic [63:0] model_ct(input logic [63:0] pt, input logic [127:0] key, input logic dec);
    if (key == '0 && !dec && pt == 64'h0)                   return 64'h818665aa0d02dfda;
    if (key == '0 && !dec && pt == 64'hffffffffffffffff)    return 64'h604ae6ca03c20ada;
    if (key == '0 &&  dec && pt == 64'h818665aa0d02dfda)    return 64'h0;
    if (key == '0 &&  dec && pt == 64'h604ae6ca03c20ada)    return 64'hffffffffffffffff;
    return {pt[31:0], pt[63:32]} ^ key[127:64] ^ (key[63:0] + 64'h9e3779b97f4a7c15) ^ {64{dec}};
  endfunction

  // Controller stub: act high on the start cycle and 10 cycles after; no reset, like the real one.
  logic       hang = 1'b0;
  logic [3:0] rem  = 4'd0;
  always @(posedge clk) begin
    if (core_st)        rem <= 4'd10;
    else if (rem != 0)  rem <= rem - 4'd1;
  end
  assign core_act = core_st | (rem != 4'd0) | hang;
  assign core_ct  = core_act ? 64'hdeadbeefdeadbeef : model_ct(core_pt, core_key, core_dec);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_job(input logic [63:0] pt, input logic [127:0] key, input logic dec, input int hold);
    logic [63:0] exp;
    int lat;
    int st_cnt;
    int waitc;
    exp = model_ct(pt, key, dec);
    waitc = 0;
    while (!in_ready && waitc < 40) begin tick(); waitc++; end
    chk("job_in_ready", in_ready, 1);
    in_pt = pt; in_key = key; in_dec = dec; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_pt = {$urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom}; in_dec = ~dec;
    lat = 1; st_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (core_st) st_cnt++;
      tick();
      lat++;
    end
    chk("job_latency", lat, 13);
    chk("job_st_pulses", st_cnt, 1);
    chk("job_core_pt", core_pt, pt);
    chk("job_core_key", core_key, key);
    chk("job_core_dec", core_dec, dec);
    chk("job_out_ct", out_ct, exp);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_ct", out_ct, exp);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("job_taken", out_valid, 0);
  endtask

  initial begin
    logic [63:0]  bpt  [3];
    logic [127:0] bkey [3];
    logic         bdec [3];
    logic [63:0]  exp_q[$];
    int           acc_cyc[$];
    int           n_acc;
    int           n_res;
    int           n;
    int           ov_cnt;
    logic [63:0]  last_ct;

    rstn = 1'b0; in_valid = 1'b0; in_pt = '0; in_key = '0; in_dec = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_st", core_st, 0);
    chk("rst_err", err, 0);
    chk("rst_core_pt", core_pt, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_dec", core_dec, 0);
    chk("rst_out_ct", out_ct, 0);
    rstn = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);

    do_job(64'h0, 128'h0, 1'b0, 0);
    do_job(64'hffffffffffffffff, 128'h0, 1'b0, 5);
    do_job(64'h818665aa0d02dfda, 128'h0, 1'b1, 0);

    for (int j = 0; j < 6; j++)
      do_job({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), $urandom_range(0, 4));

    // Back-to-back with in_valid and out_ready held high.
    for (int j = 0; j < 3; j++) begin
      bpt[j]  = {$urandom, $urandom};
      bkey[j] = {$urandom, $urandom, $urandom, $urandom};
      bdec[j] = 1'($urandom_range(0, 1));
    end
    bpt[1] = 64'h0; bkey[1] = 128'h0; bdec[1] = 1'b0;
    n_acc = 0; n_res = 0;
    in_pt = bpt[0]; in_key = bkey[0]; in_dec = bdec[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && n_res < 3; c++) begin
      logic acc;
      acc = in_valid && in_ready;
      if (acc) begin
        acc_cyc.push_back(c);
        exp_q.push_back(model_ct(in_pt, in_key, in_dec));
        n_acc++;
      end
      if (out_valid) begin
        if (exp_q.size() > 0) chk("b2b_ct", out_ct, exp_q.pop_front());
        else                  chk("b2b_spurious", out_valid, 0);
        n_res++;
      end
      tick();
      if (acc) begin
        if (n_acc < 3) begin in_pt = bpt[n_acc]; in_key = bkey[n_acc]; in_dec = bdec[n_acc]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_results", n_res, 3);
    chk("b2b_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 14);
      chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 14);
    end

    // Reset in RUN cycle 5; the controller keeps running and must block new jobs.
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    in_pt = 64'h1234; in_key = 128'h5678; in_dec = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_core_pt", core_pt, 0);
    chk("mid_rst_core_key", core_key, 0);
    chk("mid_rst_out_ct", out_ct, 0);
    chk("mid_rst_core_st", core_st, 0);
    #1;
    rstn = 1'b1;
    tick();
    n = 1; ov_cnt = 0;
    while (!in_ready && n < 40) begin
      if (out_valid) ov_cnt++;
      tick();
      n++;
    end
    chk("mid_rst_block_cycles", n, 6);
    chk("mid_rst_no_result", ov_cnt, 0);
    chk("mid_rst_act_low", core_act, 0);
    do_job(64'h604ae6ca03c20ada, 128'h0, 1'b1, 1);
    last_ct = 64'hffffffffffffffff;

    // Stuck controller.
    in_pt = 64'hcafe; in_key = 128'h0; in_dec = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hang = 1'b1;
    n = 1; ov_cnt = 0;
`ifdef PRINCE_IF_TIMEOUT_EN
    while (!err && n < 60) begin
      if (out_valid) ov_cnt++;
      tick();
      n++;
    end
    chk("to_err_cycle", n, 18);
    chk("to_err", err, 1);
    chk("to_no_valid", ov_cnt + int'(out_valid), 0);
    chk("to_in_ready_blocked", in_ready, 0);
    chk("to_out_ct_kept", out_ct, last_ct);
    hang = 1'b0;
    tick();
    chk("to_idle", in_ready, 1);
    chk("to_err_sticky", err, 1);
    chk("to_still_no_valid", out_valid, 0);
    rstn = 1'b0;
    #1;
    chk("to_err_cleared", err, 0);
    #1;
    rstn = 1'b1;
`else
    repeat (30) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    chk("hang_no_valid", ov_cnt, 0);
    chk("hang_err_zero", err, 0);
    chk("hang_in_ready", in_ready, 0);
    chk("hang_out_ct_kept", out_ct, last_ct);
    hang = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    chk("hang_release_lat", n, 1);
    chk("hang_release_ct", out_ct, model_ct(64'hcafe, 128'h0, 1'b0));
    chk("hang_release_err", err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
